shift_mul_seq: RTL

SHIFT_MUL_SEQ -- requirements
Module: shift_mul_seq

---
 rtl/shift_mul_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/shift_mul_seq.sv
// shift_mul_seq: sequential 8x8 shift-and-add multiplier (product mod 256) that borrows an external shared shifter.
// Optional feature: define SHIFT_MUL_SKIP_ZERO_EN to leave RUN once no higher multiplier bits remain.
module shift_mul_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] shf_b,
    output logic [2:0] shf_j,
    input  logic [7:0] shf_result,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       carry,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] a_q, b_q, acc_q;
    logic [2:0] k_q;
    logic [8:0] sum;
    logic       accept, add_en, last;

    // Handshake: start is a level request sampled only in IDLE (no ready, never queued);
    // done is a one-cycle valid strobe and product stays put until the next accepted start.
    assign accept = (state == IDLE) && start;
    assign add_en = a_q[k_q];
    assign sum    = {1'b0, acc_q} + {1'b0, shf_result};

`ifdef SHIFT_MUL_SKIP_ZERO_EN
    assign last = (k_q == 3'd7) || (((a_q >> k_q) >> 1) == 8'd0);
`else
    assign last = (k_q == 3'd7);
`endif

    assign shf_b     = b_q;
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        shf_j     = 3'd0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SHIFT_MUL_SKIP_ZERO_EN
                    state_nxt = (A == 8'd0) ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                busy  = 1'b1;
                shf_j = k_q;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 8'd0;
            k_q     <= 3'd0;
            product <= 8'd0;
            carry   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                acc_q <= 8'd0;
                k_q   <= 3'd0;
                carry <= 1'b0;
`ifdef SHIFT_MUL_SKIP_ZERO_EN
                if (A == 8'd0) product <= 8'd0;
`endif
            end else if (state == RUN) begin
                k_q <= k_q + 3'd1;
                if (add_en) begin
                    acc_q <= sum[7:0];
                    if (sum[8]) carry <= 1'b1;
                end
                // Load the result on the way out so it is valid throughout the DONE cycle.
                if (last) product <= add_en ? sum[7:0] : acc_q;
            end
        end
    end

endmodule
